// File: rtl/obb_pair_scheduler.sv
// Pair sweep controller for the OBB collision detector: walks every unordered body pair (a<b) once per
// frame and streams colliding pairs downstream. Optional macro SCHED_PEN_REPORT_EN adds penetration reporting.
module obb_pair_scheduler #(
  parameter int N_BODIES = 8,
  parameter int IDX_W    = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx_a,
  output logic [IDX_W-1:0] idx_b,
  input  logic             det_collision,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx_a,
  output logic [IDX_W-1:0] ev_idx_b,
`ifdef SCHED_PEN_REPORT_EN
  input  logic [31:0]      det_min_pen,
  output logic [31:0]      ev_pen,
`endif
  output logic [15:0]      hit_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t state_r;

  logic             adv_fin_s;
  logic [IDX_W-1:0] adv_a_s;
  logic [IDX_W-1:0] adv_b_s;

  // Next pair in lexicographic order, or end of sweep after the last pair.
  always_comb begin
    adv_fin_s = 1'b0;
    adv_a_s   = idx_a;
    adv_b_s   = idx_b;
    if (int'(idx_b) < (N_BODIES - 1)) begin
      adv_b_s = idx_b + IDX_W'(1'b1);
    end else if (int'(idx_a) < (N_BODIES - 2)) begin
      adv_a_s = idx_a + IDX_W'(1'b1);
      adv_b_s = idx_a + IDX_W'(2'd2);
    end else begin
      adv_fin_s = 1'b1;
    end
  end

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx_a     <= IDX_W'(1'b0);
      idx_b     <= IDX_W'(1'b1);
      ev_valid  <= 1'b0;
      ev_idx_a  <= IDX_W'(1'b0);
      ev_idx_b  <= IDX_W'(1'b0);
      hit_count <= 16'd0;
`ifdef SCHED_PEN_REPORT_EN
      ev_pen    <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            idx_a     <= IDX_W'(1'b0);
            idx_b     <= IDX_W'(1'b1);
            hit_count <= 16'd0;
            busy      <= 1'b1;
            if (N_BODIES < 2) begin
              state_r <= FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          state_r <= SAMPLE;
        end
        SAMPLE: begin
          if (det_collision) begin
            ev_idx_a <= idx_a;
            ev_idx_b <= idx_b;
`ifdef SCHED_PEN_REPORT_EN
            ev_pen   <= det_min_pen;
`endif
            ev_valid <= 1'b1;
            if (hit_count != 16'hFFFF) begin
              hit_count <= hit_count + 16'd1;
            end else begin
              hit_count <= hit_count;
            end
            state_r <= EMIT;
          end else if (adv_fin_s) begin
            state_r <= FIN;
            done    <= 1'b1;
          end else begin
            idx_a   <= adv_a_s;
            idx_b   <= adv_b_s;
            state_r <= ISSUE;
          end
        end
        EMIT: begin
          // ev_* fields stay frozen until the consumer takes the event.
          if (ev_ready) begin
            ev_valid <= 1'b0;
            if (adv_fin_s) begin
              state_r <= FIN;
              done    <= 1'b1;
            end else begin
              idx_a   <= adv_a_s;
              idx_b   <= adv_b_s;
              state_r <= ISSUE;
            end
          end else begin
            ev_valid <= 1'b1;
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obb_pair_scheduler.sv
// Directed bench for obb_pair_scheduler: four instances (N=4,3,1,8) sharing clock and reset.
module tb_obb_pair_scheduler;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  // N=4 instance
  logic       start4, busy4, done4, det4, ev_valid4, ev_ready4, hit4_en;
  logic [1:0] idx_a4, idx_b4, ev_idx_a4, ev_idx_b4;
  logic [15:0] hit4;
  // N=3 instance
  logic       start3, busy3, done3, det3, ev_valid3, ev_ready3;
  logic [1:0] idx_a3, idx_b3, ev_idx_a3, ev_idx_b3;
  logic [15:0] hit3;
  // N=1 instance
  logic       start1, busy1, done1, ev_valid1;
  logic [0:0] idx_a1, idx_b1, ev_idx_a1, ev_idx_b1;
  logic [15:0] hit1;
  // N=8 instance
  logic       start8, busy8, done8, det8, ev_valid8, ev_ready8, pen_mode;
  logic [2:0] idx_a8, idx_b8, ev_idx_a8, ev_idx_b8;
  logic [15:0] hit8;
`ifdef SCHED_PEN_REPORT_EN
  logic [31:0] pen8, ev_pen8, ev_pen4, ev_pen3, ev_pen1;
  assign pen8 = (idx_a8 == 3'd2 && idx_b8 == 3'd5) ? 32'h0080_0000 : 32'h1234_5678;
`endif

  assign det4 = hit4_en && (idx_a4 == 2'd1) && (idx_b4 == 2'd3);
  assign det8 = pen_mode && (idx_a8 == 3'd2) && (idx_b8 == 3'd5);

  obb_pair_scheduler #(.N_BODIES(4), .IDX_W(2)) u4 (
    .Clk(Clk), .Reset(Reset), .start(start4), .busy(busy4), .done(done4),
    .idx_a(idx_a4), .idx_b(idx_b4), .det_collision(det4), .ev_valid(ev_valid4),
    .ev_ready(ev_ready4), .ev_idx_a(ev_idx_a4), .ev_idx_b(ev_idx_b4),
`ifdef SCHED_PEN_REPORT_EN
    .det_min_pen(32'h0), .ev_pen(ev_pen4),
`endif
    .hit_count(hit4));

  obb_pair_scheduler #(.N_BODIES(3), .IDX_W(2)) u3 (
    .Clk(Clk), .Reset(Reset), .start(start3), .busy(busy3), .done(done3),
    .idx_a(idx_a3), .idx_b(idx_b3), .det_collision(det3), .ev_valid(ev_valid3),
    .ev_ready(ev_ready3), .ev_idx_a(ev_idx_a3), .ev_idx_b(ev_idx_b3),
`ifdef SCHED_PEN_REPORT_EN
    .det_min_pen(32'h0), .ev_pen(ev_pen3),
`endif
    .hit_count(hit3));

  obb_pair_scheduler #(.N_BODIES(1), .IDX_W(1)) u1 (
    .Clk(Clk), .Reset(Reset), .start(start1), .busy(busy1), .done(done1),
    .idx_a(idx_a1), .idx_b(idx_b1), .det_collision(1'b1), .ev_valid(ev_valid1),
    .ev_ready(1'b1), .ev_idx_a(ev_idx_a1), .ev_idx_b(ev_idx_b1),
`ifdef SCHED_PEN_REPORT_EN
    .det_min_pen(32'h0), .ev_pen(ev_pen1),
`endif
    .hit_count(hit1));

  obb_pair_scheduler #(.N_BODIES(8), .IDX_W(3)) u8 (
    .Clk(Clk), .Reset(Reset), .start(start8), .busy(busy8), .done(done8),
    .idx_a(idx_a8), .idx_b(idx_b8), .det_collision(det8), .ev_valid(ev_valid8),
    .ev_ready(ev_ready8), .ev_idx_a(ev_idx_a8), .ev_idx_b(ev_idx_b8),
`ifdef SCHED_PEN_REPORT_EN
    .det_min_pen(pen8), .ev_pen(ev_pen8),
`endif
    .hit_count(hit8));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done4); end
    checks++; if (idx_a4 !== 2'd0 || idx_b4 !== 2'd1) begin errors++; $display("FAIL reset_idx got (%0d,%0d) exp (0,1)", idx_a4, idx_b4); end
    checks++; if (ev_valid4 !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b exp 0", ev_valid4); end
    checks++; if (ev_idx_a4 !== 2'd0 || ev_idx_b4 !== 2'd0) begin errors++; $display("FAIL reset_ev_idx got (%0d,%0d) exp (0,0)", ev_idx_a4, ev_idx_b4); end
    checks++; if (hit4 !== 16'd0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit4); end
  endtask

  task automatic test_no_hit;
    logic [1:0] ea [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [1:0] eb [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
    int done_cyc = 0;
    int evs = 0;
    hit4_en = 1'b0; ev_ready4 = 1'b1;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c <= 12) begin
        checks++;
        if (idx_a4 !== ea[(c-1)/2] || idx_b4 !== eb[(c-1)/2]) begin
          errors++; $display("FAIL nohit_idx cyc %0d got (%0d,%0d) exp (%0d,%0d)", c, idx_a4, idx_b4, ea[(c-1)/2], eb[(c-1)/2]);
        end
      end
      if (c == 1) begin checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL nohit_busy got %b exp 1", busy4); end end
      if (c == 14) begin checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL nohit_idle got %b exp 0", busy4); end end
      if (ev_valid4 === 1'b1) evs++;
      if (done4 === 1'b1 && done_cyc == 0) done_cyc = c;
      tick();
    end
    checks++; if (done_cyc != 13) begin errors++; $display("FAIL nohit_done_cycle got %0d exp 13", done_cyc); end
    checks++; if (evs != 0) begin errors++; $display("FAIL nohit_events got %0d exp 0", evs); end
    checks++; if (hit4 !== 16'd0) begin errors++; $display("FAIL nohit_hit_count got %0d exp 0", hit4); end
  endtask

  task automatic test_one_hit;
    int done_cyc = 0;
    int nev = 0;
    logic [1:0] ra = 2'd0, rb = 2'd0;
    hit4_en = 1'b1; ev_ready4 = 1'b1;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (ev_valid4 === 1'b1) begin nev++; ra = ev_idx_a4; rb = ev_idx_b4; end
      if (done4 === 1'b1 && done_cyc == 0) done_cyc = c;
      tick();
    end
    hit4_en = 1'b0;
    checks++; if (nev != 1) begin errors++; $display("FAIL onehit_events got %0d exp 1", nev); end
    checks++; if (ra !== 2'd1 || rb !== 2'd3) begin errors++; $display("FAIL onehit_pair got (%0d,%0d) exp (1,3)", ra, rb); end
    checks++; if (done_cyc != 14) begin errors++; $display("FAIL onehit_done_cycle got %0d exp 14", done_cyc); end
    checks++; if (hit4 !== 16'd1) begin errors++; $display("FAIL onehit_hit_count got %0d exp 1", hit4); end
  endtask

  task automatic test_stall;
    logic [1:0] ea [3] = '{2'd0, 2'd0, 2'd1};
    logic [1:0] eb [3] = '{2'd1, 2'd2, 2'd2};
    logic [1:0] ha = 2'd0, hb = 2'd0;
    int stall = 0;
    int nev = 0;
    bit seen_done = 1'b0;
    det3 = 1'b1; ev_ready3 = 1'b0;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int c = 1; c <= 200 && !seen_done; c++) begin
      if (ev_valid3 === 1'b1) begin
        if (stall == 0) begin
          ha = ev_idx_a3; hb = ev_idx_b3;
        end else begin
          checks++;
          if (ev_idx_a3 !== ha || ev_idx_b3 !== hb) begin
            errors++; $display("FAIL stall_stable got (%0d,%0d) exp (%0d,%0d)", ev_idx_a3, ev_idx_b3, ha, hb);
          end
        end
        if (stall < 5) begin
          ev_ready3 = 1'b0; stall++;
        end else begin
          ev_ready3 = 1'b1; stall = 0;
          checks++;
          if (nev >= 3) begin
            errors++; $display("FAIL stall_extra_event got %0d events exp 3", nev + 1);
          end else if (ev_idx_a3 !== ea[nev] || ev_idx_b3 !== eb[nev]) begin
            errors++; $display("FAIL stall_order ev %0d got (%0d,%0d) exp (%0d,%0d)", nev, ev_idx_a3, ev_idx_b3, ea[nev], eb[nev]);
          end
          nev++;
        end
      end else begin
        ev_ready3 = 1'b0;
      end
      if (done3 === 1'b1) seen_done = 1'b1;
      tick();
    end
    det3 = 1'b0; ev_ready3 = 1'b0;
    checks++; if (!seen_done) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
    checks++; if (nev != 3) begin errors++; $display("FAIL stall_events got %0d exp 3", nev); end
    checks++; if (hit3 !== 16'd3) begin errors++; $display("FAIL stall_hit_count got %0d exp 3", hit3); end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    int done_cyc = 0;
    hit4_en = 1'b0; ev_ready4 = 1'b1;
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick(); tick(); tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL midrst_busy_done got (%b,%b) exp (0,0)", busy4, done4); end
    checks++; if (idx_a4 !== 2'd0 || idx_b4 !== 2'd1) begin errors++; $display("FAIL midrst_idx got (%0d,%0d) exp (0,1)", idx_a4, idx_b4); end
    checks++; if (ev_valid4 !== 1'b0 || hit4 !== 16'd0) begin errors++; $display("FAIL midrst_ev_hit got (%b,%0d) exp (0,0)", ev_valid4, hit4); end
    for (int c = 0; c < 20; c++) begin
      if (done4 === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done4 === 1'b1 && done_cyc == 0) done_cyc = c;
      tick();
    end
    checks++; if (done_cyc != 13) begin errors++; $display("FAIL midrst_resweep_done got %0d exp 13", done_cyc); end
  endtask

  task automatic test_n1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL n1_done got (%b,%b) exp (1,1)", done1, busy1); end
    checks++; if (ev_valid1 !== 1'b0) begin errors++; $display("FAIL n1_ev_valid got %b exp 0", ev_valid1); end
    tick();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL n1_after got (%b,%b) exp (0,0)", done1, busy1); end
  endtask

  task automatic test_busy_ignored;
    int ndone = 0;
    int done_cyc = 0;
    pen_mode = 1'b0; ev_ready8 = 1'b1;
    start8 = 1'b1; tick(); start8 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      start8 = (c == 10) ? 1'b1 : 1'b0;
      if (done8 === 1'b1) begin ndone++; if (done_cyc == 0) done_cyc = c; end
      tick();
    end
    start8 = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_pulses got %0d exp 1", ndone); end
    checks++; if (done_cyc != 57) begin errors++; $display("FAIL busy_done_cycle got %0d exp 57", done_cyc); end
  endtask

`ifdef SCHED_PEN_REPORT_EN
  task automatic test_pen;
    int stall = 0;
    bit got = 1'b0;
    bit seen_done = 1'b0;
    pen_mode = 1'b1; ev_ready8 = 1'b0;
    start8 = 1'b1; tick(); start8 = 1'b0;
    for (int c = 1; c <= 300 && !seen_done; c++) begin
      if (ev_valid8 === 1'b1) begin
        checks++;
        if (ev_pen8 !== 32'h0080_0000 || ev_idx_a8 !== 3'd2 || ev_idx_b8 !== 3'd5) begin
          errors++; $display("FAIL pen_hold got %h (%0d,%0d) exp 00800000 (2,5)", ev_pen8, ev_idx_a8, ev_idx_b8);
        end
        if (stall < 3) begin ev_ready8 = 1'b0; stall++; end
        else begin ev_ready8 = 1'b1; got = 1'b1; end
      end else begin
        ev_ready8 = 1'b0;
      end
      if (done8 === 1'b1) seen_done = 1'b1;
      tick();
    end
    pen_mode = 1'b0;
    checks++; if (!got || !seen_done) begin errors++; $display("FAIL pen_event got (%b,%b) exp (1,1)", got, seen_done); end
    checks++; if (hit8 !== 16'd1) begin errors++; $display("FAIL pen_hit_count got %0d exp 1", hit8); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1;
    start4 = 1'b0; start3 = 1'b0; start1 = 1'b0; start8 = 1'b0;
    hit4_en = 1'b0; det3 = 1'b0; pen_mode = 1'b0;
    ev_ready4 = 1'b1; ev_ready3 = 1'b0; ev_ready8 = 1'b1;
    test_reset();
    test_no_hit();
    test_one_hit();
    test_stall();
    test_reset_mid();
    test_n1();
    test_busy_ignored();
`ifdef SCHED_PEN_REPORT_EN
    test_pen();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
